ws_sta_feeder: RTL and testbench
================================

Name: ws_sta_feeder

Overview:
Operand sequencer that drives the A, B and propagate-B inputs of the weight-stationary systolic array (16 A lanes, 64 B lanes).
- Command interface: on a start pulse, loads one weight tile row-by-row from a valid/ready weight stream with propagate-B asserted.
- Streams a programmed number of activation vectors from a valid/ready activation stream.
- Drains the pipeline with zeros, then pulses done.
- Sits between the operand buffers and the array.

Parameters:
ROWS, 16, number of A lanes / propagate-B lanes / weight rows per tile
COLS, 64, number of B lanes
DW, 8, operand width in bits
LEN_W, 16, width of the activation vector count
DRAIN_CYC, 80, zero cycles driven after the last activation before done

Ports:
clock  in  1  single clock, all state on rising edge
reset  in  1  asynchronous, active-high; all state and outputs cleared immediately
start  in  1  one-cycle command pulse; ignored unless idle
cfg_len  in  LEN_W  activation vectors to stream; sampled on accepted start
w_valid  in  1  weight beat valid
w_ready  out  1  feeder accepts weight beat
w_data  in  COLS*DW  one weight row; lane k at bits [k*DW +: DW]
a_valid  in  1  activation beat valid
a_ready  out  1  feeder accepts activation beat
a_data  in  ROWS*DW  one activation vector; lane i at bits [i*DW +: DW]
io_inputA  out  ROWS*DW  to array A inputs
io_inputB  out  COLS*DW  to array B inputs
io_propagateB  out  ROWS  to array propagate-B inputs
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse on DRAIN->IDLE

Behaviour:
- Reset values: all outputs 0, state IDLE, all counters 0, skew registers 0.
- States: IDLE, LOAD, STREAM, DRAIN.

IDLE:
- w_ready=0, a_ready=0.
- start=1 latches cfg_len and clears counters.
- Next state is LOAD.

LOAD:
- w_ready=1.
- On w_valid&w_ready, in the same cycle: io_inputB=w_data, io_propagateB=all ones, row counter +1.
- Any cycle without a fire: io_inputB=0, io_propagateB=0 (a stall inserts a bubble; the array must not shift weights).
- After ROWS fires, go to STREAM, or to DRAIN if the latched len=0.
- w_ready drops the cycle after the ROWS-th fire.

STREAM:
- a_ready=1, io_propagateB=0, io_inputB=0.
- On a_valid&a_ready: io_inputA=a_data, vector counter +1.
- Any cycle without a fire: io_inputA=0.
- After len fires, go to DRAIN.
- len=65535 must complete with no counter wrap; the counter is LEN_W bits and compares against the latched len.

DRAIN:
- All array outputs 0, both readies 0.
- Lasts exactly DRAIN_CYC cycles (plus ROWS-1 if skew is enabled).
- done=1 is asserted in the final DRAIN cycle; the state is IDLE on the next edge.

Ordering, latency and boundary rules:
- Combinational path: io_* outputs are combinational from the stream data plus fire. Zero latency from an accepted beat to the array input in the non-skew build.
- No skid buffer: w_ready and a_ready are registered state decodes only, never dependent on valid.
- start while busy: ignored, with no effect on cfg_len.
- start in the same cycle done pulses: ignored, because the state is still DRAIN.
- Reset mid-operation: immediate IDLE, outputs zero, with no done pulse. Partially loaded weights are abandoned, and upstream must resend the whole tile.
- Ignored beats: w_valid in a non-LOAD state and a_valid in a non-STREAM state are ignored and never consumed.

Optional Feature:
Macro WS_FEEDER_SKEW_EN.
- Defined: io_inputA lane i is delayed by i cycles through a per-lane shift register, so lane 0 is undelayed and lane 15 is delayed 15 cycles. Bubbles propagate as zeros through the delay lines. DRAIN is extended by ROWS-1 cycles so the last skewed element leaves before done. The shift registers clear on reset and shift every cycle in every state.
- Not defined: all A lanes are aligned (the array performs its own skew), and DRAIN is exactly DRAIN_CYC cycles.

Test Plan:
1. Reset with all inputs 0, then deassert → all outputs 0, busy=0; with a_valid=w_valid=1 held, no beat is consumed.
2. start with cfg_len=4; 16 weight beats back-to-back, w_data lane k = k+row → io_propagateB=16'hFFFF for exactly 16 cycles, io_inputB mirrors each row; then 4 activations (lane i = i+1) appear on io_inputA unskewed; busy stays 1; done is a single pulse after 80 drain cycles; total busy cycles = 1+16+4+80.
3. Weight stream with w_valid low on rows 3 and 9 → io_propagateB=0 and io_inputB=0 in those gap cycles; still exactly 16 asserted propagate cycles; transition to STREAM only after the 16th fire.
4. cfg_len=0 → LOAD goes straight to DRAIN; a_ready is never 1; done arrives 80 cycles after the last weight.
5. Assert reset during STREAM after 2 of 4 vectors → outputs 0 within the same cycle (asynchronous); busy=0; no done; a new start then runs the full sequence normally.
6. With WS_FEEDER_SKEW_EN defined, one activation of all 8'h11 → lane i shows 8'h11 exactly i cycles after the fire, zero otherwise; DRAIN lasts 95 cycles.

Source files
------------

// File: rtl/ws_sta_feeder.sv
// Operand sequencer for the weight-stationary systolic array: loads a weight tile,
// streams activations, drains with zeros. Optional A-lane skew under WS_FEEDER_SKEW_EN.
module ws_sta_feeder #(
    parameter int ROWS      = 16,
    parameter int COLS      = 64,
    parameter int DW        = 8,
    parameter int LEN_W     = 16,
    parameter int DRAIN_CYC = 80
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [LEN_W-1:0]     cfg_len,
    input  logic                 w_valid,
    output logic                 w_ready,
    input  logic [COLS*DW-1:0]   w_data,
    input  logic                 a_valid,
    output logic                 a_ready,
    input  logic [ROWS*DW-1:0]   a_data,
    output logic [ROWS*DW-1:0]   io_inputA,
    output logic [COLS*DW-1:0]   io_inputB,
    output logic [ROWS-1:0]      io_propagateB,
    output logic                 busy,
    output logic                 done
);

`ifdef WS_FEEDER_SKEW_EN
    localparam int SKEW_EXTRA = ROWS - 1;
`else
    localparam int SKEW_EXTRA = 0;
`endif
    localparam int DRAIN_LEN = DRAIN_CYC + SKEW_EXTRA;
    localparam int DRN_W     = $clog2(DRAIN_LEN + 1);
    localparam int ROW_W     = $clog2(ROWS + 1);

    typedef enum logic [1:0] {IDLE, LOAD, STREAM, DRAIN} state_e;

    state_e             state_q;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   vec_q;
    logic [ROW_W-1:0]   row_q;
    logic [DRN_W-1:0]   drn_q;

    logic               w_fire;
    logic               a_fire;
    logic [ROWS*DW-1:0] a_vec;

    assign w_fire = (state_q == LOAD) && w_valid;
    assign a_fire = (state_q == STREAM) && a_valid;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            len_q   <= '0;
            vec_q   <= '0;
            row_q   <= '0;
            drn_q   <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        len_q   <= cfg_len;
                        vec_q   <= '0;
                        row_q   <= '0;
                        drn_q   <= '0;
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    if (w_valid) begin
                        row_q <= row_q + ROW_W'(1);
                        if (row_q == ROW_W'(ROWS - 1))
                            state_q <= (len_q == '0) ? DRAIN : STREAM;
                    end
                end
                STREAM: begin
                    // Compare against len-1 so len = 2^LEN_W-1 finishes without wrapping.
                    if (a_valid) begin
                        vec_q <= vec_q + LEN_W'(1);
                        if (vec_q == len_q - LEN_W'(1))
                            state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    drn_q <= drn_q + DRN_W'(1);
                    if (drn_q == DRN_W'(DRAIN_LEN - 1))
                        state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy    = (state_q != IDLE);
    assign w_ready = (state_q == LOAD);
    assign a_ready = (state_q == STREAM);
    assign done    = (state_q == DRAIN) && (drn_q == DRN_W'(DRAIN_LEN - 1));

    // Stalls must present zeros so the array never shifts a stale weight row.
    assign io_inputB     = w_fire ? w_data : '0;
    assign io_propagateB = {ROWS{w_fire}};
    assign a_vec         = a_fire ? a_data : '0;

`ifdef WS_FEEDER_SKEW_EN
    for (genvar i = 0; i < ROWS; i++) begin : g_lane
        if (i == 0) begin : g_nodly
            assign io_inputA[0 +: DW] = a_vec[0 +: DW];
        end else begin : g_dly
            logic [DW-1:0] dly_q [i];
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    for (int j = 0; j < i; j++) dly_q[j] <= '0;
                end else begin
                    dly_q[0] <= a_vec[i*DW +: DW];
                    for (int j = 1; j < i; j++) dly_q[j] <= dly_q[j-1];
                end
            end
            assign io_inputA[i*DW +: DW] = dly_q[i-1];
        end
    end
`else
    assign io_inputA = a_vec;
`endif

endmodule

// File: tb/tb_ws_sta_feeder.sv
// Randomized self-checking bench for ws_sta_feeder; expectations come from the
// phase plan the bench itself drives plus a history queue for A-lane skew.
module tb_ws_sta_feeder;
    localparam int ROWS = 16, COLS = 64, DW = 8, LEN_W = 16, DRAIN_CYC = 80;
`ifdef WS_FEEDER_SKEW_EN
    localparam int SKEW = 1;
`else
    localparam int SKEW = 0;
`endif
    localparam int DLEN = DRAIN_CYC + SKEW * (ROWS - 1);

    logic clock = 1'b0, reset = 1'b1, start = 1'b0;
    logic [LEN_W-1:0] cfg_len = '0;
    logic w_valid = 1'b0, a_valid = 1'b0;
    logic [COLS*DW-1:0] w_data = '0;
    logic [ROWS*DW-1:0] a_data = '0;
    logic w_ready, a_ready, busy, done;
    logic [ROWS*DW-1:0] io_inputA;
    logic [COLS*DW-1:0] io_inputB;
    logic [ROWS-1:0] io_propagateB;

    int n_tests = 0, n_fail = 0, span = 0;
    logic [ROWS*DW-1:0] hist[$];

    ws_sta_feeder #(.ROWS(ROWS), .COLS(COLS), .DW(DW), .LEN_W(LEN_W), .DRAIN_CYC(DRAIN_CYC)) dut (
        .clock(clock), .reset(reset), .start(start), .cfg_len(cfg_len),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
        .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
        .io_inputA(io_inputA), .io_inputB(io_inputB), .io_propagateB(io_propagateB),
        .busy(busy), .done(done));

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [COLS*DW-1:0] got, input logic [COLS*DW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h exp %h", tag, got, exp);
        end
    endtask

    // Lane i shows the vector accepted i cycles ago when skewed, else the current one.
    function automatic logic [ROWS*DW-1:0] exp_a();
        logic [ROWS*DW-1:0] r = '0;
        for (int i = 0; i < ROWS; i++) begin
            int idx = hist.size() - 1 - SKEW * i;
            if (idx >= 0) r[i*DW +: DW] = hist[idx][i*DW +: DW];
        end
        return r;
    endfunction

    function automatic logic [COLS*DW-1:0] rnd_w();
        logic [COLS*DW-1:0] r;
        for (int k = 0; k < COLS*DW/32; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [ROWS*DW-1:0] rnd_a();
        logic [ROWS*DW-1:0] r;
        for (int k = 0; k < ROWS*DW/32; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    // One clock: record accepted A vector, check at negedge, advance past posedge.
    task automatic cyc(input logic wr, input logic ar, input logic bsy, input logic dn,
                       input logic [ROWS-1:0] pb, input logic [COLS*DW-1:0] eb,
                       input logic [ROWS*DW-1:0] acc);
        hist.push_back(acc);
        if (hist.size() > ROWS) void'(hist.pop_front());
        @(negedge clock);
        chk("ctl", COLS*DW'({w_ready, a_ready, busy, done, io_propagateB}), COLS*DW'({wr, ar, bsy, dn, pb}));
        chk("inputB", io_inputB, eb);
        chk("inputA", COLS*DW'(io_inputA), COLS*DW'(exp_a()));
        span++;
        @(posedge clock);
        #1;
    endtask

    // wm/am: 0 back-to-back with fixed patterns, 1 gaps on rows 3 and 9, 2 random valid.
    // apat 3 drives all lanes 8'h11. abort>=0 returns mid-STREAM after that many vectors.
    task automatic run_op(input int len, input int wm, input int am, input int apat, input int abort);
        int row = 0, vec = 0;
        logic v, prev_gap = 1'b0;
        start = 1'b1; cfg_len = LEN_W'(len);
        w_valid = $urandom_range(0, 1); a_valid = $urandom_range(0, 1);
        span = 0;
        cyc(0, 0, 0, 0, '0, '0, '0);
        start = 1'b0;
        while (row < ROWS) begin
            if (wm == 1) v = !((row == 3 || row == 9) && !prev_gap);
            else if (wm == 2) v = ($urandom_range(0, 3) != 0);
            else v = 1'b1;
            prev_gap = !v;
            w_valid = v;
            if (wm == 0) for (int k = 0; k < COLS; k++) w_data[k*DW +: DW] = DW'(k + row);
            else w_data = rnd_w();
            a_valid = $urandom_range(0, 1); a_data = rnd_a();
            start = $urandom_range(0, 1); cfg_len = LEN_W'($urandom);
            cyc(1, 0, 1, 0, v ? '1 : '0, v ? w_data : '0, '0);
            if (v) row++;
        end
        while (vec < len) begin
            if (vec == abort) begin a_valid = 1'b1; start = 1'b0; return; end
            v = (am == 2) ? ($urandom_range(0, 2) != 0) : 1'b1;
            a_valid = v;
            if (apat == 3) a_data = {ROWS{8'h11}};
            else if (am == 0) for (int i = 0; i < ROWS; i++) a_data[i*DW +: DW] = DW'(i + 1);
            else a_data = rnd_a();
            w_valid = $urandom_range(0, 1); w_data = rnd_w();
            start = $urandom_range(0, 1); cfg_len = LEN_W'($urandom);
            cyc(0, 1, 1, 0, '0, '0, v ? a_data : '0);
            if (v) vec++;
        end
        for (int k = 0; k < DLEN; k++) begin
            w_valid = $urandom_range(0, 1); a_valid = $urandom_range(0, 1);
            w_data = rnd_w(); a_data = rnd_a();
            start = (k == DLEN - 1) ? 1'b1 : 1'(($urandom_range(0, 1)));
            cfg_len = LEN_W'($urandom);
            cyc(0, 0, 1, (k == DLEN - 1), '0, '0, '0);
        end
        if (wm == 0 && am == 0) chk("busy_span", COLS*DW'(span), COLS*DW'(1 + ROWS + len + DLEN));
        start = 1'b0; w_valid = 1'b1; a_valid = 1'b1;
        cyc(0, 0, 0, 0, '0, '0, '0);
        w_valid = 1'b0; a_valid = 1'b0;
    endtask

    initial begin
        // Reset state, then held valids must not be consumed while idle.
        cyc(0, 0, 0, 0, '0, '0, '0);
        reset = 1'b0;
        w_valid = 1'b1; a_valid = 1'b1; w_data = rnd_w(); a_data = rnd_a();
        repeat (3) cyc(0, 0, 0, 0, '0, '0, '0);
        w_valid = 1'b0; a_valid = 1'b0;

        run_op(4, 0, 0, 0, -1);
        run_op(3, 1, 0, 0, -1);
        run_op(0, 0, 0, 0, -1);
        run_op(1, 0, 0, 3, -1);

        // Asynchronous reset mid-STREAM with a_valid still high.
        run_op(4, 0, 0, 0, 2);
        #2 reset = 1'b1;
        #1;
        chk("rst_ctl", COLS*DW'({w_ready, a_ready, busy, done, io_propagateB}), '0);
        chk("rst_inputA", COLS*DW'(io_inputA), '0);
        chk("rst_inputB", io_inputB, '0);
        @(posedge clock); #1;
        hist.delete();
        a_valid = 1'b0;
        repeat (2) cyc(0, 0, 0, 0, '0, '0, '0);
        reset = 1'b0;
        cyc(0, 0, 0, 0, '0, '0, '0);
        run_op(4, 0, 0, 0, -1);

        for (int t = 0; t < 6; t++) run_op($urandom_range(0, 20), 2, 2, 0, -1);
        run_op(300, 2, 2, 0, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
